// File: rtl/prom_boot_copier_if.sv
// ---------------------------------------------------------------------------
// prom_boot_copier_if : PROM, RAM-write and boot status bundle of the copier
// Rev 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

interface prom_boot_copier_if #(
  parameter int RAM_AW = 18
);
  logic              start;
  logic              prom_en;
  logic [9:0]        prom_addr;
  logic [31:0]       prom_data;
  logic              ram_wr;
  logic [RAM_AW-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic              ram_ack;
  logic              busy;
  logic              done;
  logic              cpu_rst_n;
  logic [31:0]       checksum;

  modport master (
    input  start, prom_data, ram_ack,
    output prom_en, prom_addr, ram_wr, ram_addr, ram_wdata,
           busy, done, cpu_rst_n, checksum
  );

  modport slave (
    output start, prom_data, ram_ack,
    input  prom_en, prom_addr, ram_wr, ram_addr, ram_wdata,
           busy, done, cpu_rst_n, checksum
  );
endinterface

`default_nettype wire

// File: rtl/prom_boot_copier.sv
// ---------------------------------------------------------------------------
// prom_boot_copier : copies the boot PROM image into RAM, holds CPU in reset
// Rev 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module prom_boot_copier #(
  parameter int                NUM_WORDS  = 1024,
  parameter int                RAM_AW     = 18,
  parameter logic [RAM_AW-1:0] RAM_BASE   = '0,
  parameter bit                AUTO_START = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  prom_boot_copier_if.master         bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [9:0] c_LAST = 10'(NUM_WORDS - 1);

  state_t            r_state;
  logic [9:0]        r_index;
  logic [31:0]       r_checksum;
  logic [RAM_AW-1:0] r_ram_addr;
  logic              r_ram_wr;
  logic              r_busy;
  logic              r_done;
  logic              r_cpu_rst_n;

  logic w_last;
  logic w_advance;
  logic w_start_ok;

  assign w_last     = (r_index == c_LAST);
  assign w_advance  = (r_state == S_WRITE) && bus.ram_ack && !w_last;
  assign w_start_ok = ((r_state == S_IDLE) && (AUTO_START || bus.start)) ||
                      ((r_state == S_DONE) && bus.start);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_index     <= '0;
      r_checksum  <= '0;
      r_ram_addr  <= RAM_BASE;
      r_ram_wr    <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_cpu_rst_n <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_start_ok) begin
            r_state     <= S_FETCH;
            r_index     <= '0;
            r_checksum  <= '0;
            r_ram_addr  <= RAM_BASE;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
            r_cpu_rst_n <= 1'b0;
          end
        end
        S_FETCH: begin
          r_state  <= S_WRITE;
          r_ram_wr <= 1'b1;
        end
        S_WRITE: begin
          // Without an ack nothing moves, so the PROM output and the write hold.
          if (bus.ram_ack) begin
            r_checksum <= r_checksum + bus.prom_data;
            if (w_last) begin
              r_state     <= S_DONE;
              r_ram_wr    <= 1'b0;
              r_busy      <= 1'b0;
              r_done      <= 1'b1;
              r_cpu_rst_n <= 1'b1;
            end else begin
              r_index    <= r_index + 10'd1;
              r_ram_addr <= r_ram_addr + RAM_AW'(1);
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Next word is requested in the ack cycle so it arrives as the write advances.
  assign bus.prom_en   = (r_state == S_FETCH) || w_advance;
  assign bus.prom_addr = w_advance ? (r_index + 10'd1) : r_index;

  assign bus.ram_wr    = r_ram_wr;
  assign bus.ram_addr  = r_ram_addr;
  assign bus.ram_wdata = r_ram_wr ? bus.prom_data : 32'd0;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.cpu_rst_n = r_cpu_rst_n;
  assign bus.checksum  = r_checksum;

endmodule

`default_nettype wire

// File: tb/tb_prom_boot_copier.sv
// ---------------------------------------------------------------------------
// tb_prom_boot_copier : directed checks of three copier configurations
// Rev 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_prom_boot_copier;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a;
  logic rst_b;
  logic rst_c;

  int total = 0;
  int bad   = 0;

  prom_boot_copier_if #(.RAM_AW(18)) bus_a ();
  prom_boot_copier_if #(.RAM_AW(10)) bus_b ();
  prom_boot_copier_if #(.RAM_AW(18)) bus_c ();

  prom_boot_copier #(.NUM_WORDS(1024), .RAM_AW(18), .RAM_BASE(18'h0),   .AUTO_START(1'b1))
    u_a (.clk(clk), .rst_n(rst_a), .bus(bus_a));
  prom_boot_copier #(.NUM_WORDS(4),    .RAM_AW(10), .RAM_BASE(10'h3FE), .AUTO_START(1'b1))
    u_b (.clk(clk), .rst_n(rst_b), .bus(bus_b));
  prom_boot_copier #(.NUM_WORDS(8),    .RAM_AW(18), .RAM_BASE(18'h20),  .AUTO_START(1'b0))
    u_c (.clk(clk), .rst_n(rst_c), .bus(bus_c));

  logic [31:0] prom_b [4] = '{32'hFFFF_FFFF, 32'h0000_0002, 32'h8000_0000, 32'h8000_0000};

  // PROM models: synchronous read, output held while enable is low
  always_ff @(posedge clk) if (bus_a.prom_en) bus_a.prom_data <= {22'd0, bus_a.prom_addr};
  always_ff @(posedge clk) if (bus_b.prom_en) bus_b.prom_data <= prom_b[bus_b.prom_addr[1:0]];
  always_ff @(posedge clk) if (bus_c.prom_en) bus_c.prom_data <= 32'hA500_0000 + {22'd0, bus_c.prom_addr};

  int          a_cnt = 0;
  int          a_err = 0;
  logic [31:0] a_exp = 32'd0;
  int          c_cnt = 0;
  int          c_err = 0;
  int          c_fetch = 0;
  logic [31:0] c_exp = 32'd0;

  // Accepted-write monitors; a FETCH cycle marks the start of a new copy
  always @(negedge clk) begin
    if (rst_a) begin
      if (bus_a.prom_en && !bus_a.ram_wr) begin
        a_exp = 32'd0;
        a_cnt = 0;
      end else if (bus_a.ram_wr && bus_a.ram_ack) begin
        if (bus_a.ram_addr != a_exp[17:0] || bus_a.ram_wdata != a_exp) a_err++;
        a_exp++;
        a_cnt++;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_c) begin
      if (bus_c.prom_en && !bus_c.ram_wr) begin
        c_exp = 32'd0;
        c_cnt = 0;
        c_fetch++;
      end else if (bus_c.ram_wr && bus_c.ram_ack) begin
        if (bus_c.ram_addr != (18'h20 + c_exp[17:0]) || bus_c.ram_wdata != (32'hA500_0000 + c_exp)) c_err++;
        c_exp++;
        c_cnt++;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_a(input string tag);
    chk({tag, "_ctl"}, {bus_a.prom_en, bus_a.ram_wr, bus_a.busy, bus_a.done, bus_a.cpu_rst_n}, 5'b0);
    chk({tag, "_addr"}, {bus_a.prom_addr, bus_a.ram_addr}, 28'd0);
    chk({tag, "_data"}, {bus_a.ram_wdata, bus_a.checksum}, 64'd0);
  endtask

  task automatic wait_done_a(inout int cyc);
    while (!bus_a.done && cyc < 1100) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          cyc;
    int          idle_err;
    logic [9:0]  ea;

    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    bus_a.start = 1'b0; bus_a.ram_ack = 1'b1;
    bus_b.start = 1'b0; bus_b.ram_ack = 1'b0;
    bus_c.start = 1'b0; bus_c.ram_ack = 1'b1;
    #1;
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_a("a_rst");
    chk("b_rst_addr", bus_b.ram_addr, 10'h3FE);

    // ---- A: full 1024-word auto copy, ack always high
    @(negedge clk); rst_a = 1'b1;
    @(posedge clk); #1;
    chk("a_fetch", {bus_a.busy, bus_a.prom_en, bus_a.ram_wr, bus_a.prom_addr}, {1'b1, 1'b1, 1'b0, 10'd0});
    @(posedge clk); #1;
    chk("a_first_wr", {bus_a.ram_wr, bus_a.ram_addr, bus_a.ram_wdata}, {1'b1, 18'd0, 32'd0});
    chk("a_first_next", {bus_a.prom_en, bus_a.prom_addr}, {1'b1, 10'd1});
    cyc = 2;
    wait_done_a(cyc);
    chk("a_done_cycle", cyc, 1026);
    chk("a_cpu_rel", {bus_a.done, bus_a.cpu_rst_n, bus_a.busy}, 3'b110);
    chk("a_sum", bus_a.checksum, 32'h0007_FE00);
    chk("a_writes", a_cnt, 1024);

    // ---- A: restart from DONE
    bus_a.start = 1'b1;
    @(posedge clk); #1;
    bus_a.start = 1'b0;
    chk("a_restart", {bus_a.done, bus_a.cpu_rst_n, bus_a.busy, bus_a.checksum}, {1'b0, 1'b0, 1'b1, 32'd0});
    cyc = 1;
    wait_done_a(cyc);
    chk("a2_done_cycle", cyc, 1026);
    chk("a2_sum", bus_a.checksum, 32'h0007_FE00);
    chk("a2_writes", a_cnt, 1024);

    // ---- A: reset pulse during write of index 500
    bus_a.start = 1'b1;
    @(posedge clk); #1;
    bus_a.start = 1'b0;
    cyc = 0;
    while (!(bus_a.ram_wr && bus_a.ram_addr == 18'd500) && cyc < 1100) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("a_reach500", bus_a.ram_addr, 18'd500);
    #1;
    rst_a = 1'b0;
    #1;
    chk_reset_a("a_abort");
    @(negedge clk); rst_a = 1'b1;
    cyc = 0;
    wait_done_a(cyc);
    chk("a3_done_cycle", cyc, 1026);
    chk("a3_sum", bus_a.checksum, 32'h0007_FE00);
    chk("a3_writes", a_cnt, 1024);
    chk("a_data_err", a_err, 0);

    // ---- B: 4 words, 3 stall cycles per write, address wrap in 10 bits
    @(negedge clk); rst_b = 1'b1;
    @(posedge clk); #1;
    chk("b_fetch", {bus_b.busy, bus_b.prom_en, bus_b.prom_addr}, {1'b1, 1'b1, 10'd0});
    for (int w = 0; w < 4; w++) begin
      ea = 10'h3FE + 10'(w);
      for (int s = 0; s < 4; s++) begin
        @(posedge clk); #1;
        bus_b.ram_ack = (s == 3);
        #1;
        chk($sformatf("b_wr%0d_%0d", w, s), {bus_b.ram_wr, bus_b.ram_addr, bus_b.ram_wdata}, {1'b1, ea, prom_b[w]});
        if (s == 3 && w < 3)
          chk($sformatf("b_next%0d", w), {bus_b.prom_en, bus_b.prom_addr}, {1'b1, 10'(w + 1)});
        else
          chk($sformatf("b_hold%0d_%0d", w, s), bus_b.prom_en, 1'b0);
      end
    end
    chk("b_not_done_yet", {bus_b.done, bus_b.cpu_rst_n, bus_b.busy}, 3'b001);
    @(posedge clk); #1;
    bus_b.ram_ack = 1'b0;
    chk("b_done", {bus_b.done, bus_b.cpu_rst_n, bus_b.busy, bus_b.ram_wr}, 4'b1100);
    chk("b_sum", bus_b.checksum, 32'h0000_0001);

    // ---- C: manual start, start pulses during WRITE ignored
    @(negedge clk); rst_c = 1'b1;
    idle_err = 0;
    repeat (100) begin
      @(posedge clk); #1;
      if (bus_c.busy || bus_c.prom_en || bus_c.ram_wr || bus_c.cpu_rst_n || bus_c.done) idle_err++;
    end
    chk("c_idle", idle_err, 0);
    bus_c.start = 1'b1;
    @(posedge clk); #1;
    bus_c.start = 1'b0;
    chk("c_fetch", {bus_c.busy, bus_c.prom_en, bus_c.prom_addr}, {1'b1, 1'b1, 10'd0});
    @(posedge clk); #1;
    chk("c_first_wr", {bus_c.ram_wr, bus_c.ram_addr, bus_c.ram_wdata}, {1'b1, 18'h20, 32'hA500_0000});
    cyc = 2;
    repeat (3) begin
      bus_c.start = 1'b1;
      @(posedge clk); #1;
      bus_c.start = 1'b0;
      @(posedge clk); #1;
      cyc += 2;
    end
    while (!bus_c.done && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("c_done_cycle", cyc, 10);
    chk("c_writes", c_cnt, 8);
    chk("c_fetches", c_fetch, 1);
    chk("c_data_err", c_err, 0);
    chk("c_sum", bus_c.checksum, 32'h2800_001C);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
